// File: rtl/serial_compare_unit_pkg.sv
// Shared definitions for the serial signed comparator.
//   state_t        : FSM encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand width
//   DEFAULT_CHUNK  : default bits processed per RUN cycle
package serial_compare_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_compare_unit_if.sv
// Handshake/operand bus for serial_compare_unit.
//   start          : launch request (master -> slave)
//   data_operandA  : signed operand A (master -> slave)
//   data_operandB  : signed operand B (master -> slave)
//   busy           : comparison in progress (slave -> master)
//   done           : one-cycle result-valid pulse (slave -> master)
//   isNotEqual     : A != B, held until next done (slave -> master)
//   isLessThan     : A < B signed, held until next done (slave -> master)
interface serial_compare_unit_if
    import serial_compare_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             busy;
    logic             done;
    logic             isNotEqual;
    logic             isLessThan;

    modport master (
        output start, data_operandA, data_operandB,
        input  busy, done, isNotEqual, isLessThan
    );

    modport slave (
        input  start, data_operandA, data_operandB,
        output busy, done, isNotEqual, isLessThan
    );
endinterface

// File: rtl/serial_compare_unit_chunk_subtractor.sv
// One chunk of the A - B borrow chain, computed as a + ~b + cin.
//   a, b : CHUNK-bit operand slices
//   cin  : incoming carry (1 for the first chunk)
//   sum  : CHUNK-bit difference slice
//   cout : carry into the next chunk
module serial_compare_unit_chunk_subtractor #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/serial_compare_unit.sv
// Multi-cycle signed comparator: computes A - B CHUNK bits per cycle,
// carrying the borrow chain across cycles, then reports not-equal and
// signed less-than with two's-complement overflow correction.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : serial_compare_unit_if.slave (start/operands in, busy/done/results out)
// All outputs come from flops; there is no input-to-output combinational path.
module serial_compare_unit
    import serial_compare_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_compare_unit_if.slave bus
);
    localparam int                NCHUNK = WIDTH / CHUNK;
    localparam int                CNT_W  = $clog2(NCHUNK) + 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("serial_compare_unit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             a_msb, b_msb;
    logic             carry, nz;
    logic [CNT_W-1:0] count;
    logic             is_ne, is_lt;

    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             accept, last;
    logic             nz_final, ovf;

    serial_compare_unit_chunk_subtractor #(.CHUNK(CHUNK)) u_sub (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back relaunch straight from DONE.
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The top chunk's sum MSB is the sign of the wrapped difference; flip it
    // when A and B have opposite signs and the difference sign disagrees with A.
    assign nz_final = nz | (|sum);
    assign ovf      = (a_msb ^ b_msb) & (sum[CHUNK-1] ^ a_msb);

    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            carry <= 1'b0;
            nz    <= 1'b0;
            count <= '0;
            is_ne <= 1'b0;
            is_lt <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.data_operandA;
            b_sh  <= bus.data_operandB;
            a_msb <= bus.data_operandA[WIDTH-1];
            b_msb <= bus.data_operandB[WIDTH-1];
            carry <= 1'b1;
            nz    <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            carry <= cout;
            nz    <= nz_final;
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            count <= count + 1'b1;
            if (last) begin
                is_ne <= nz_final | ovf;
                is_lt <= sum[CHUNK-1] ^ ovf;
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.isNotEqual = is_ne;
    assign bus.isLessThan = is_lt;

endmodule

// File: tb/tb_serial_compare_unit.sv
// Directed bench: dut0 uses CHUNK=8 (4 RUN cycles), dut1 uses CHUNK=32
// (single RUN cycle). Both share clock and reset.
module tb_serial_compare_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    serial_compare_unit_if #(.WIDTH(32)) bus0 ();
    serial_compare_unit_if #(.WIDTH(32)) bus1 ();

    serial_compare_unit #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    serial_compare_unit #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ne;
        logic        lt;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) begin
            bus0.start = s; bus0.data_operandA = a; bus0.data_operandB = b;
        end else begin
            bus1.start = s; bus1.data_operandA = a; bus1.data_operandB = b;
        end
    endtask

    // {busy, done, isNotEqual, isLessThan}
    function automatic logic [3:0] obs(input int sel);
        if (sel == 0) return {bus0.busy, bus0.done, bus0.isNotEqual, bus0.isLessThan};
        return {bus1.busy, bus1.done, bus1.isNotEqual, bus1.isLessThan};
    endfunction

    task automatic test_reset();
        logic [3:0] o;
        // start asserted together with reset must not launch anything
        reset = 1'b1;
        drive(0, 1'b1, 32'd3, 32'd7);
        drive(1, 1'b1, 32'd3, 32'd7);
        tick();
        tick();
        for (int sel = 0; sel < 2; sel++) begin
            o = obs(sel);
            checks++;
            if (o !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%b exp=0000", sel, o);
            end
        end
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        for (int sel = 0; sel < 2; sel++) begin
            o = obs(sel);
            checks++;
            if (o !== 4'b0000) begin
                failures++;
                $display("FAIL idle_after_reset dut%0d got=%b exp=0000", sel, o);
            end
        end
    endtask

    task automatic test_vectors();
        logic [3:0] o;
        for (int sel = 0; sel < 2; sel++) begin
            int nch;
            nch = (sel == 0) ? 4 : 1;
            for (int i = 0; i < NV; i++) begin
                int lat, nbusy;
                drive(sel, 1'b1, vecs[i].a, vecs[i].b);
                tick();
                // operands change right after acceptance; must not matter
                drive(sel, 1'b0, 32'hDEADBEEF, 32'h0);
                lat = 0; nbusy = 0;
                o = obs(sel);
                while (!o[2] && lat < 20) begin
                    if (o[3]) nbusy++;
                    tick();
                    lat++;
                    o = obs(sel);
                end
                checks++;
                if (lat != nch || nbusy != nch) begin
                    failures++;
                    $display("FAIL latency dut%0d vec%0d got lat=%0d busy=%0d exp %0d/%0d",
                             sel, i, lat, nbusy, nch, nch);
                end
                checks++;
                if (o[1:0] !== {vecs[i].ne, vecs[i].lt}) begin
                    failures++;
                    $display("FAIL result dut%0d vec%0d got ne,lt=%b exp=%b%b",
                             sel, i, o[1:0], vecs[i].ne, vecs[i].lt);
                end
                tick();
                o = obs(sel);
                checks++;
                if (o !== {2'b00, vecs[i].ne, vecs[i].lt}) begin
                    failures++;
                    $display("FAIL hold dut%0d vec%0d got=%b exp=00%b%b",
                             sel, i, o, vecs[i].ne, vecs[i].lt);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] o, first;
        int k, ndone, kfirst;
        drive(0, 1'b1, 32'd3, 32'd7);
        tick();                                 // accepting edge
        drive(0, 1'b0, 32'd0, 32'd0);
        tick();
        drive(0, 1'b1, 32'd9, 32'd2);           // mid-RUN start
        tick();
        drive(0, 1'b0, 32'd0, 32'd0);
        k = 2; ndone = 0; kfirst = -1; first = 4'b0;
        while (k < 14) begin
            o = obs(0);
            if (o[2]) begin
                ndone++;
                if (kfirst < 0) begin kfirst = k; first = o; end
            end
            tick();
            k++;
        end
        checks++;
        if (ndone != 1 || kfirst != 4) begin
            failures++;
            $display("FAIL start_ignored_done got count=%0d at=%0d exp 1 at 4", ndone, kfirst);
        end
        checks++;
        if (first[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL start_ignored_result got=%b exp=11", first[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] o;
        int ndone, lat;
        drive(0, 1'b1, 32'h8000_0000, 32'h0000_0001);
        tick();                                 // accept
        drive(0, 1'b0, 32'd0, 32'd0);
        tick();                                 // in RUN cycle 2
        reset = 1'b1;
        tick();
        o = obs(0);
        checks++;
        if (o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=0000", o);
        end
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            o = obs(0);
            if (o[2] || o[3]) ndone++;
            tick();
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got activity=%0d exp=0", ndone);
        end
        // fresh operation: -1 vs 0
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        tick();
        drive(0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        o = obs(0);
        while (!o[2] && lat < 20) begin
            tick();
            lat++;
            o = obs(0);
        end
        checks++;
        if (lat != 4 || o[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL after_reset_op got lat=%0d ne,lt=%b exp lat=4 ne,lt=11", lat, o[1:0]);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] o;
        for (int sel = 0; sel < 2; sel++) begin
            int nch, idx, cyc, lastc;
            nch = (sel == 0) ? 4 : 1;
            drive(sel, 1'b1, vecs[1].a, vecs[1].b);
            idx = 0; cyc = 0; lastc = 0;
            tick();                             // first accept
            while (idx < 4 && cyc < 100) begin
                o = obs(sel);
                if (o[2]) begin
                    checks++;
                    if (o[1:0] !== {vecs[idx+1].ne, vecs[idx+1].lt}) begin
                        failures++;
                        $display("FAIL b2b_result dut%0d op%0d got=%b exp=%b%b",
                                 sel, idx, o[1:0], vecs[idx+1].ne, vecs[idx+1].lt);
                    end
                    checks++;
                    if ((idx == 0 && cyc != nch) || (idx > 0 && cyc - lastc != nch + 1)) begin
                        failures++;
                        $display("FAIL b2b_timing dut%0d op%0d got cyc=%0d prev=%0d nch=%0d",
                                 sel, idx, cyc, lastc, nch);
                    end
                    lastc = cyc;
                    idx++;
                    if (idx < 4) drive(sel, 1'b1, vecs[idx+1].a, vecs[idx+1].b);
                    else         drive(sel, 1'b0, 32'd0, 32'd0);
                end
                tick();
                cyc++;
            end
            checks++;
            if (idx != 4) begin
                failures++;
                $display("FAIL b2b_timeout dut%0d got ops=%0d exp=4", sel, idx);
            end
            drive(sel, 1'b0, 32'd0, 32'd0);
            tick();
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{32'd5,         32'd5,         1'b0, 1'b0};
        vecs[1] = '{32'd3,         32'd7,         1'b1, 1'b1};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFF7, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1};
        vecs[6] = '{32'h0100_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);

        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
